memoria_dados_param: RTL and testbench
======================================

# memoria_dados_param

Parametrised single-port data memory for the processor datapath, replacing the fixed 16x16 data memory. Generalises width and depth. Adds:
- per-byte write enables;
- an access-enable/valid pair;
- a sequential initialisation engine that fills every word with a fill constant after reset or on request, with a `Ready` flag the control unit polls before issuing loads/stores.

Reads and writes complete in one cycle; writes are write-through to `Q`.

## Interface
- `DATA_WIDTH`, 16, word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 4, address width; `DEPTH = 2**ADDR_WIDTH` words.
- `INIT_VALUE`, 7, word written to every location during initialisation (`DATA_WIDTH` bits).
- `Clock` input 1: single clock, all state updates on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Clear` input 1: synchronous request to re-run initialisation.
- `En` input 1: access request, sampled on the clock edge.
- `wren` input 1: 1 = write, 0 = read (meaningful only with `En`=1).
- `ByteEn` input `DATA_WIDTH/8`: write lane mask; bit k covers `Din[8k+7:8k]`.
- `Address` input `ADDR_WIDTH`: word address.
- `Din` input `DATA_WIDTH`: write data.
- `Q` output `DATA_WIDTH`: registered read/write-through data.
- `Valid` output 1: `Q` updated by an access on the previous edge.
- `Ready` output 1: memory initialised and accepting accesses.

## Operation
- **States:** INIT, RUN. Internal sweep counter `InitAddr` is `ADDR_WIDTH` bits.
- **Reset asserted (async):**
  - state=INIT, `InitAddr`=0;
  - `Q`=0, `Valid`=0, `Ready`=0;
  - array contents untouched until the sweep.
- **INIT, each edge:**
  - `mem[InitAddr]` <= `INIT_VALUE`; `InitAddr`++;
  - `En` ignored; `Valid`<=0; `Q` holds.
  - When `InitAddr`==DEPTH-1: write the last word, go to RUN, `Ready`<=1, `InitAddr` wraps to 0.
- **RUN, `Clear`=1:**
  - go to INIT, `InitAddr`<=0, `Ready`<=0, `Valid`<=0;
  - `Clear` wins over a simultaneous `En`: the access is dropped, no write occurs.
- **RUN, `Clear`=0, `En`=1, `wren`=1:**
  - for each lane k with `ByteEn[k]`=1, `mem[Address]` lane k <= `Din` lane k; other lanes keep their old value;
  - `Q` <= merged word (new lanes from `Din`, old lanes from memory);
  - `Valid`<=1.
- **RUN, `En`=1, `wren`=0:** `Q` <= `mem[Address]`, `Valid`<=1; `ByteEn` ignored.
- **RUN, `En`=1, `wren`=1, `ByteEn`=0:** no array change; `Q` <= old word; `Valid`<=1.
- **RUN, `En`=0:** `Q` holds; `Valid`<=0.
- **`Clear` during INIT:** restarts the sweep at 0 (`InitAddr`<=0 on that edge; no write that cycle).
- **Back-to-back accesses:** every edge accepted. A read of an address written on the previous edge returns the new data; no hazard window.
- **Address range:** the full range is valid; no out-of-range case.

## Timing
- **Access latency:** 1 edge. An access sampled on edge N gives `Q`/`Valid` after edge N.
- **Init duration:** exactly DEPTH edges after `Reset` deasserts (or after the `Clear` edge). `Ready` rises after the DEPTH-th edge; 16 edges with defaults.
- **Registered outputs:** `Ready`, `Valid` and `Q` are all registered; no combinational path from inputs to outputs.
- **Reset mid-access or mid-sweep:** outputs return to reset values immediately. Any partially swept contents are overwritten by the new sweep.
- **Caller rule:** the caller must not assert `En` while `Ready`=0. If it does, the request is silently dropped and `Valid` stays 0.

## Test plan
- **Reset and sweep:** assert `Reset` for 2 cycles, release; hold `En`=0.
  - `Ready`=0 for 16 edges, 1 after edge 16.
  - Read all 16 addresses: each returns 0x0007 with `Valid`=1 one edge later.
- **Full-word write/read:**
  - Write `Address`=3, `Din`=0xBEEF, `ByteEn`=11 -> `Q`=0xBEEF and `Valid`=1 on the same edge.
  - Read address 3 next cycle -> `Q`=0xBEEF.
- **Byte-lane write:** with `mem[5]`=0x1234, write `Din`=0xABCD, `ByteEn`=01 -> `Q`=0x12CD. A subsequent read of 5 -> 0x12CD.
- **Clear priority:** in RUN, assert `Clear` together with a write of 0xFFFF to address 0.
  - `Ready` drops next edge and returns after 16 edges.
  - Address 0 reads 0x0007.
- **Access during INIT:** drive `En`=1, `wren`=1, `Address`=2, `Din`=0x5555 during the sweep.
  - `Valid` stays 0.
  - After `Ready`, address 2 reads 0x0007.
- **Async reset mid-operation:** pulse `Reset` between clock edges during a burst of reads -> `Q`=0, `Valid`=0, `Ready`=0 immediately, before the next edge.

Source files
------------

// File: rtl/memoria_dados_param_if.sv
// Access bus of the parametrised data memory.
// The control unit drives requests on the master side; the memory answers on the slave side.
interface memoria_dados_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                      Clear;
  logic                      En;
  logic                      wren;
  logic [DATA_WIDTH/8-1:0]   ByteEn;
  logic [ADDR_WIDTH-1:0]     Address;
  logic [DATA_WIDTH-1:0]     Din;
  logic [DATA_WIDTH-1:0]     Q;
  logic                      Valid;
  logic                      Ready;

  modport master (
    output Clear, En, wren, ByteEn, Address, Din,
    input  Q, Valid, Ready
  );

  modport slave (
    input  Clear, En, wren, ByteEn, Address, Din,
    output Q, Valid, Ready
  );
endinterface

// File: rtl/memoria_dados_param.sv
// Parametrised single-port data memory with per-byte write enables,
// a registered read/write-through output and a sequential fill engine
// that writes INIT_VALUE to every word after reset or on Clear.
module memoria_dados_param #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(32'd7)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  memoria_dados_param_if.slave  bus
);

  localparam int                    LANES     = DATA_WIDTH / 8;
  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(32'd1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic [DATA_WIDTH-1:0]   old_word_s;
  logic [DATA_WIDTH-1:0]   merged_word_s;

  // Replace the lanes selected by be with the matching lanes of din.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] din,
    input logic [LANES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int k = 0; k < LANES; k++) begin
      if (be[k]) begin
        w[8*k +: 8] = din[8*k +: 8];
      end else begin
        w[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return w;
  endfunction

  assign old_word_s    = mem_q[bus.Address];
  assign merged_word_s = merge_lanes(old_word_s, bus.Din, bus.ByteEn);

  // Next-state, output and array-write decode for the INIT/RUN controller.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    q_d         = q_q;
    valid_d     = 1'b0;
    ready_d     = ready_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = bus.Address;
    mem_wdata_s = merged_word_s;

    case (state_q)
      ST_INIT: begin
        if (bus.Clear) begin
          // Restart the sweep; nothing is written on this edge.
          init_addr_d = ADDR_ZERO;
        end else begin
          mem_we_s    = ~Reset;
          mem_addr_s  = init_addr_q;
          mem_wdata_s = INIT_VALUE;
          init_addr_d = init_addr_q + ADDR_ONE;
          if (init_addr_q == LAST_ADDR) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_INIT;
          end
        end
      end
      ST_RUN: begin
        if (bus.Clear) begin
          // Clear beats a simultaneous access: the request is dropped.
          state_d     = ST_INIT;
          init_addr_d = ADDR_ZERO;
          ready_d     = 1'b0;
        end else if (bus.En) begin
          valid_d = 1'b1;
          if (bus.wren) begin
            mem_we_s = (|bus.ByteEn) & ~Reset;
            q_d      = merged_word_s;
          end else begin
            q_d = old_word_s;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = ADDR_ZERO;
        ready_d     = 1'b0;
      end
    endcase
  end

  // Controller and output registers; reset returns outputs to idle at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= ADDR_ZERO;
      q_q         <= {DATA_WIDTH{1'b0}};
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  // Storage array; deliberately not reset, the sweep provides known contents.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign bus.Q     = q_q;
  assign bus.Valid = valid_q;
  assign bus.Ready = ready_q;

endmodule

// File: tb/tb_memoria_dados_param.sv
// Directed bench for memoria_dados_param with a behavioural reference model
// compared on every falling edge, plus literal expectations on key results.
module tb_memoria_dados_param;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [15:0] INIT_W = 16'h0007;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  memoria_dados_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memoria_dados_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // sweep_left counts the initialisation edges still owed; zero means ready.
  logic [15:0] mem_m [DEPTH];
  int          sweep_left = DEPTH;
  logic [15:0] m_q        = 16'h0000;
  logic        m_valid    = 1'b0;

  function automatic logic [15:0] access_word(input logic [15:0] old_w, input logic [15:0] din,
                                              input logic [1:0] be, input logic wr);
    logic [15:0] w;
    w = old_w;
    if (wr) begin
      if (be[0]) w[7:0]  = din[7:0];
      if (be[1]) w[15:8] = din[15:8];
    end
    return w;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sweep_left <= DEPTH;
      m_q        <= 16'h0000;
      m_valid    <= 1'b0;
    end else if (sweep_left > 0) begin
      m_valid <= 1'b0;
      if (bus.Clear) begin
        sweep_left <= DEPTH;
      end else begin
        mem_m[DEPTH - sweep_left] <= INIT_W;
        sweep_left <= sweep_left - 1;
      end
    end else if (bus.Clear) begin
      sweep_left <= DEPTH;
      m_valid    <= 1'b0;
    end else if (bus.En) begin
      m_valid <= 1'b1;
      m_q     <= access_word(mem_m[bus.Address], bus.Din, bus.ByteEn, bus.wren);
      if (bus.wren) mem_m[bus.Address] <= access_word(mem_m[bus.Address], bus.Din, bus.ByteEn, 1'b1);
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge Clock) begin
    check("model_q", {16'h0000, bus.Q}, {16'h0000, m_q});
    check("model_valid", {31'd0, bus.Valid}, {31'd0, m_valid});
    check("model_ready", {31'd0, bus.Ready}, {31'd0, (sweep_left == 0)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.Clear   = 1'b0;
    bus.En      = 1'b0;
    bus.wren    = 1'b0;
    bus.ByteEn  = 2'b00;
    bus.Address = 4'h0;
    bus.Din     = 16'h0000;
  endtask

  // One access on the next edge; returns Q/Valid sampled just after it.
  task automatic access(input logic wr, input logic [3:0] a, input logic [15:0] d,
                        input logic [1:0] be, output logic [15:0] q, output logic v);
    @(negedge Clock);
    bus.En = 1'b1; bus.wren = wr; bus.Address = a; bus.Din = d; bus.ByteEn = be;
    @(posedge Clock); #1;
    q = bus.Q; v = bus.Valid;
    idle_inputs();
  endtask

  // Wait until Ready rises; returns the number of edges taken (0 on timeout).
  task automatic wait_ready(input int limit, output int edges);
    edges = 0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge Clock); #1;
      if (bus.Valid !== 1'b0) check("valid_during_init", {31'd0, bus.Valid}, 32'd0);
      if (bus.Ready) begin
        edges = n;
        break;
      end
    end
    if (edges == 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] rq;
  logic        rv;
  int          edges;

  initial begin
    idle_inputs();
    #1 Reset = 1'b1;
    #1;
    check("reset_q", {16'h0000, bus.Q}, 32'd0);
    check("reset_valid", {31'd0, bus.Valid}, 32'd0);
    check("reset_ready", {31'd0, bus.Ready}, 32'd0);
    @(posedge Clock); @(posedge Clock);
    @(negedge Clock); Reset = 1'b0;

    // Ready low for 15 edges, high after the 16th.
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge Clock); #1;
      check($sformatf("sweep_ready_%0d", i), {31'd0, bus.Ready}, (i == DEPTH) ? 32'd1 : 32'd0);
    end

    for (int a = 0; a < DEPTH; a++) begin
      access(1'b0, 4'(a), 16'h0000, 2'b00, rq, rv);
      check($sformatf("init_word_%0d", a), {16'h0000, rq}, 32'h0007);
      check("init_read_valid", {31'd0, rv}, 32'd1);
    end

    // Full-word write, write-through, then read back.
    access(1'b1, 4'd3, 16'hBEEF, 2'b11, rq, rv);
    check("wr3_q", {16'h0000, rq}, 32'hBEEF);
    check("wr3_valid", {31'd0, rv}, 32'd1);
    access(1'b0, 4'd3, 16'h0000, 2'b00, rq, rv);
    check("rd3_q", {16'h0000, rq}, 32'hBEEF);

    // Byte-lane merge.
    access(1'b1, 4'd5, 16'h1234, 2'b11, rq, rv);
    access(1'b1, 4'd5, 16'hABCD, 2'b01, rq, rv);
    check("lane_wr5_q", {16'h0000, rq}, 32'h12CD);
    access(1'b0, 4'd5, 16'h0000, 2'b11, rq, rv);
    check("lane_rd5_q", {16'h0000, rq}, 32'h12CD);
    access(1'b1, 4'd5, 16'h9900, 2'b10, rq, rv);
    check("lane_hi_q", {16'h0000, rq}, 32'h99CD);
    access(1'b1, 4'd5, 16'hFFFF, 2'b00, rq, rv);
    check("lane_none_q", {16'h0000, rq}, 32'h99CD);
    check("lane_none_valid", {31'd0, rv}, 32'd1);

    // Idle cycle: Valid drops, Q holds.
    @(posedge Clock); #1;
    check("idle_valid", {31'd0, bus.Valid}, 32'd0);
    check("idle_q_hold", {16'h0000, bus.Q}, 32'h99CD);

    // Clear wins over a simultaneous write; accesses during the sweep are dropped.
    @(negedge Clock);
    bus.Clear = 1'b1; bus.En = 1'b1; bus.wren = 1'b1;
    bus.Address = 4'd0; bus.Din = 16'hFFFF; bus.ByteEn = 2'b11;
    @(posedge Clock); #1;
    check("clear_ready_drop", {31'd0, bus.Ready}, 32'd0);
    check("clear_valid", {31'd0, bus.Valid}, 32'd0);
    bus.Clear = 1'b0; bus.Address = 4'd2; bus.Din = 16'h5555;
    wait_ready(40, edges);
    check("clear_init_edges", edges, 32'd16);
    idle_inputs();
    access(1'b0, 4'd0, 16'h0000, 2'b00, rq, rv);
    check("clear_addr0", {16'h0000, rq}, 32'h0007);
    access(1'b0, 4'd2, 16'h0000, 2'b00, rq, rv);
    check("init_access_addr2", {16'h0000, rq}, 32'h0007);

    // Clear during the sweep restarts it.
    @(negedge Clock); bus.Clear = 1'b1;
    @(posedge Clock); #1; bus.Clear = 1'b0;
    repeat (5) @(posedge Clock);
    @(negedge Clock); bus.Clear = 1'b1;
    @(posedge Clock); #1; bus.Clear = 1'b0;
    wait_ready(40, edges);
    check("restart_init_edges", edges, 32'd16);

    // Burst of reads, then an asynchronous reset between edges.
    access(1'b1, 4'd9, 16'hC3A5, 2'b11, rq, rv);
    @(negedge Clock);
    bus.En = 1'b1; bus.wren = 1'b0; bus.Address = 4'd9;
    @(posedge Clock); #1;
    check("burst_q", {16'h0000, bus.Q}, 32'hC3A5);
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    check("async_q", {16'h0000, bus.Q}, 32'd0);
    check("async_valid", {31'd0, bus.Valid}, 32'd0);
    check("async_ready", {31'd0, bus.Ready}, 32'd0);
    #1 Reset = 1'b0;
    idle_inputs();
    wait_ready(40, edges);
    check("post_reset_edges", edges, 32'd16);
    access(1'b0, 4'd9, 16'h0000, 2'b00, rq, rv);
    check("post_reset_addr9", {16'h0000, rq}, 32'h0007);

    @(posedge Clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
